// File: rtl/alu_seq.sv
// Handshaked sequential ALU: legacy 8-op map plus SUB/OR, iterative shifts and
// shift-add multiply, with registered result and zero/carry flags.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 4,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  opcode,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd,
    output logic             is_zero,
    output logic             rd_zero,
    output logic             carry
);

    localparam int CNT_W = SH_W + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] KIND_SHL = 2'd0;
    localparam logic [1:0] KIND_SHR = 2'd1;
    localparam logic [1:0] KIND_MUL = 2'd2;

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_MOVB = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(9);
    localparam logic [OP_W-1:0] OP_SHL  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_SHR  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(12);

    logic [1:0]         state;
    logic [1:0]         kind;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;

    logic               accept;
    logic [SH_W-1:0]    sh_amt;
    logic [WIDTH:0]     add_w;
    logic [WIDTH-1:0]   res_1c;
    logic               carry_1c;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] step_acc;
    logic               step_carry;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign sh_amt    = rs2[SH_W-1:0];

    // Results of ops that complete at the accept edge; zero-length shifts fall
    // into the default and pass rs1 through with carry clear.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        add_w    = {1'b0, rs1} + {1'b0, rs2};
        res_1c   = rs1;
        carry_1c = 1'b0;
        case (opcode)
            OP_ADD:  begin res_1c = add_w[WIDTH-1:0]; carry_1c = add_w[WIDTH]; end
            OP_AND:  res_1c = rs1 & rs2;
            OP_XOR:  res_1c = rs1 ^ rs2;
            OP_MOVB: res_1c = rs2;
            OP_SUB:  begin res_1c = rs1 - rs2; carry_1c = (rs1 < rs2); end
            OP_OR:   res_1c = rs1 | rs2;
            default: ;
        endcase
    end

    // One iteration of the multi-cycle ops. Shifts use the low half of acc;
    // MUL keeps {partial product, remaining multiplier} in acc.
    always_comb begin
        mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
        step_acc   = {mul_sum, acc[WIDTH-1:1]};
        step_carry = |step_acc[2*WIDTH-1:WIDTH];
        case (kind)
            KIND_SHL: begin
                step_acc   = {{WIDTH{1'b0}}, acc[WIDTH-2:0], 1'b0};
                step_carry = acc[WIDTH-1];
            end
            KIND_SHR: begin
                step_acc   = {{WIDTH{1'b0}}, 1'b0, acc[WIDTH-1:1]};
                step_carry = acc[0];
            end
            default: ;
        endcase
    end

    // Accept can only happen in IDLE or DONE, so it takes priority over both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state   <= IDLE;
            kind    <= KIND_SHL;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            rd      <= '0;
            is_zero <= 1'b0;
            rd_zero <= 1'b0;
            carry   <= 1'b0;
        end else if (accept) begin
            is_zero <= (rs1 == '0);
            mcand   <= rs1;
            acc     <= {{WIDTH{1'b0}}, (opcode == OP_MUL) ? rs2 : rs1};
            if (opcode == OP_MUL) begin
                kind  <= KIND_MUL;
                cnt   <= CNT_W'(WIDTH);
                state <= BUSY;
            end else if ((opcode == OP_SHL || opcode == OP_SHR) && sh_amt != '0) begin
                kind  <= (opcode == OP_SHL) ? KIND_SHL : KIND_SHR;
                cnt   <= {1'b0, sh_amt};
                state <= BUSY;
            end else begin
                rd      <= res_1c;
                rd_zero <= (res_1c == '0);
                carry   <= carry_1c;
                state   <= DONE;
            end
        end else if (state == BUSY) begin
            acc <= step_acc;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                rd      <= step_acc[WIDTH-1:0];
                rd_zero <= (step_acc[WIDTH-1:0] == '0);
                carry   <= step_carry;
                state   <= DONE;
            end
        end else if (state == DONE && out_ready) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes model results at accept, a
// monitor checks every presented result, latency and handshake invariants.
module tb_alu_seq;

    localparam int W    = 8;
    localparam int OP_W = 4;

    typedef struct {
        logic [W-1:0] rd;
        logic         is_zero;
        logic         rd_zero;
        logic         carry;
        int           lat;
        int           acc_cycle;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [OP_W-1:0] opcode = '0;
    logic [W-1:0]    rs1 = '0;
    logic [W-1:0]    rs2 = '0;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    rd;
    logic            is_zero;
    logic            rd_zero;
    logic            carry;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cycle = 0;
    int   ready_mode = 0;

    alu_seq #(.WIDTH(W), .OP_W(OP_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rs1(rs1), .rs2(rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .rd(rd), .is_zero(is_zero), .rd_zero(rd_zero), .carry(carry)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference: plain arithmetic on wide integers, latency from the op rules.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint unsigned ua  = a;
        longint unsigned ub  = b;
        longint unsigned m   = 64'd1 << W;
        longint unsigned r   = ua;
        bit              c   = 1'b0;
        int              k   = int'(b % W);
        int              lat = 1;
        case (op)
            4'd2:  begin r = ua + ub; c = (r >= m); end
            4'd3:  r = ua & ub;
            4'd4:  r = ua ^ ub;
            4'd5:  r = ub;
            4'd8:  begin r = ua + m - ub; c = (ua < ub); end
            4'd9:  r = ua | ub;
            4'd10: if (k != 0) begin r = ua << k; c = ((r >> W) & 1) != 0; lat = k + 1; end
            4'd11: if (k != 0) begin r = ua >> k; c = ((ua >> (k - 1)) & 1) != 0; lat = k + 1; end
            4'd12: begin r = ua * ub; c = (r >> W) != 0; lat = W + 1; end
            default: r = ua;
        endcase
        r           = r % m;
        e.rd        = W'(r);
        e.rd_zero   = (r == 0);
        e.is_zero   = (ua == 0);
        e.carry     = c;
        e.lat       = lat;
        e.acc_cycle = 0;
        return e;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        bit   done = 1'b0;
        e        = model(op, a, b);
        opcode   = op;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                done        = 1'b1;
                e.acc_cycle = cycle;
            end
            @(posedge clk);
            if (done) q.push_back(e);
            #1;
        end
        in_valid = 1'b0;
        check("accept", done, 1'b1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", q.size(), 0);
    endtask

    // out_ready driver: 0 = high, 1 = held low, 2 = random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: compares whatever the DUT presents against the queue head.
    initial begin
        bit seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
                continue;
            end
            if (q.size() == 0) begin
                check("idle_out_valid", out_valid, 1'b0);
                check("idle_in_ready", in_ready, 1'b1);
            end else if (!out_valid) begin
                check("busy_in_ready", in_ready, 1'b0);
            end else begin
                if (!seen) begin
                    check("latency", cycle - q[0].acc_cycle, q[0].lat);
                    seen = 1'b1;
                end
                check("rd", rd, q[0].rd);
                check("is_zero", is_zero, q[0].is_zero);
                check("rd_zero", rd_zero, q[0].rd_zero);
                check("carry", carry, q[0].carry);
                check("done_in_ready", in_ready, out_ready);
                if (out_ready) begin
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_rd", rd, 0);
        check("rst_flags", {is_zero, rd_zero, carry}, 3'b000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Legacy map and the zero-operand case
        for (int op = 0; op < 8; op++) issue(4'(op), 8'h42, 8'h86);
        issue(4'd7, 8'h00, 8'h55);

        // New single-cycle ops, shifts and multiply corners
        issue(4'd8, 8'h42, 8'h86);
        issue(4'd2, 8'hFF, 8'h01);
        issue(4'd10, 8'h81, 8'h03);
        issue(4'd11, 8'h81, 8'h01);
        issue(4'd10, 8'h5A, 8'h00);
        issue(4'd11, 8'h80, 8'h07);
        issue(4'd12, 8'h12, 8'h10);
        issue(4'd12, 8'h05, 8'h03);
        issue(4'd12, 8'hFF, 8'hFF);
        wait_drain();

        // Backpressure hold, then back-to-back stream
        ready_mode = 1;
        issue(4'd2, 8'h33, 8'h44);
        repeat (7) @(posedge clk);
        #1;
        ready_mode = 0;
        for (int i = 0; i < 4; i++) issue(4'd2, 8'($urandom), 8'($urandom));
        wait_drain();

        // Randomised mix under random consumer stalls
        ready_mode = 2;
        for (int i = 0; i < 80; i++) begin
            logic [W-1:0] b;
            b = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            issue(4'($urandom_range(0, 15)), 8'($urandom), b);
        end
        ready_mode = 0;
        wait_drain();

        // Reset during the 4th BUSY cycle of a multiply discards the result
        issue(4'd12, 8'h12, 8'h10);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_rd", rd, 0);
        check("midrst_carry", carry, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        issue(4'd12, 8'h05, 8'h03);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
